// File: rtl/rename_sequencer.sv
// Sequences the shared rename port between decode allocations and buffered retire releases,
// tracks the free physical-register count and registers rename results toward dispatch.
module rename_sequencer #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int FREE_INIT     = 32,
    parameter int RETQ_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    input  logic       ret_valid,
    output logic       ret_ready,
    input  logic [5:0] ret_phys_reg,
    output logic       ren_issue_valid,
    output logic       ren_retire_valid,
    output logic [4:0] ren_rs1,
    output logic [4:0] ren_rs2,
    output logic [4:0] ren_rd,
    output logic [5:0] ren_retire_phys_reg,
    input  logic [5:0] ren_phys_rd,
    input  logic [5:0] ren_phys_rs1,
    input  logic [5:0] ren_phys_rs2,
    input  logic [5:0] ren_old_phys_rd,
    input  logic       ren_free_list_empty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_phys_rd,
    output logic [5:0] out_phys_rs1,
    output logic [5:0] out_phys_rs2,
    output logic [5:0] out_old_phys_rd,
    output logic [6:0] free_count,
    output logic       err
);
    localparam int AW = $clog2(RETQ_DEPTH);
    localparam int SW = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [6:0]    FREE_MAX   = 7'(NUM_PHYS_REGS);
    localparam logic [6:0]    FREE_RST   = 7'(FREE_INIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [SW-1:0] STARVE_ONE = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_RECLAIM = 1'b1} state_e;

    state_e        state_r, state_s;
    logic [5:0]    fifo_mem_r [RETQ_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic [SW-1:0] starve_cnt_r, starve_next_s;
    logic [6:0]    free_count_r, free_next_s;
    logic          err_r, err_next_s;
    logic          out_valid_r;
    logic [5:0]    out_rd_r, out_rs1_r, out_rs2_r, out_old_r;
    logic          fifo_empty_s, fifo_full_s, enq_s, capture_s;
    logic          slot_free_s, can_issue_s, issue_grant_s, retire_grant_s;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign enq_s        = ret_valid & ~fifo_full_s;
    assign capture_s    = issue_grant_s & ~ren_free_list_empty;

    // Grant arbitration: retire wins whenever the queue has work and issue is blocked or starving it.
    always_comb begin
        slot_free_s    = ~out_valid_r | out_ready;
        can_issue_s    = reset_n & dec_valid & slot_free_s & (free_count_r != 7'd0) & (state_r == ST_RUN);
        retire_grant_s = 1'b0;
        if (reset_n && !fifo_empty_s &&
            ((state_r == ST_RECLAIM) || fifo_full_s || (starve_cnt_r == STARVE_MAX) || !can_issue_s)) begin
            retire_grant_s = 1'b1;
        end else begin
            retire_grant_s = 1'b0;
        end
        issue_grant_s = can_issue_s & ~retire_grant_s;
    end

    // Free-count, error and starvation bookkeeping for the coming edge.
    always_comb begin
        free_next_s   = free_count_r;
        err_next_s    = err_r;
        starve_next_s = starve_cnt_r;
        if (issue_grant_s) begin
            if (ren_free_list_empty) begin
                err_next_s = 1'b1;
            end else begin
                free_next_s = free_count_r - 7'd1;
            end
        end else if (retire_grant_s) begin
            if (free_count_r == FREE_MAX) begin
                err_next_s = 1'b1;
            end else begin
                free_next_s = free_count_r + 7'd1;
            end
        end else begin
            free_next_s = free_count_r;
        end
        if (retire_grant_s || fifo_empty_s) begin
            starve_next_s = '0;
        end else if (issue_grant_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_next_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_next_s = starve_cnt_r;
        end
    end

    // RUN/RECLAIM next state: reclaim once the pool is drained, resume after a retire refills it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (free_next_s == 7'd0) state_s = ST_RECLAIM;
                else                     state_s = ST_RUN;
            end
            ST_RECLAIM: begin
                if (retire_grant_s && (free_next_s != 7'd0)) state_s = ST_RUN;
                else                                         state_s = ST_RECLAIM;
            end
            default: state_s = ST_RUN;
        endcase
    end

    // Retire queue storage; stale entries are harmless because pointers gate every read.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= ret_phys_reg;
        end
    end

    // Control state, queue pointers and the registered result stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_RUN;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            starve_cnt_r <= '0;
            free_count_r <= FREE_RST;
            err_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_rd_r     <= 6'd0;
            out_rs1_r    <= 6'd0;
            out_rs2_r    <= 6'd0;
            out_old_r    <= 6'd0;
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_next_s;
            free_count_r <= free_next_s;
            err_r        <= err_next_s;
            if (enq_s)          wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (retire_grant_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (capture_s) begin
                out_valid_r <= 1'b1;
                out_rd_r    <= ren_phys_rd;
                out_rs1_r   <= ren_phys_rs1;
                out_rs2_r   <= ren_phys_rs2;
                out_old_r   <= ren_old_phys_rd;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign dec_ready           = issue_grant_s;
    assign ret_ready           = ~fifo_full_s;
    assign ren_issue_valid     = issue_grant_s;
    assign ren_retire_valid    = retire_grant_s;
    assign ren_rs1             = issue_grant_s ? dec_rs1 : 5'd0;
    assign ren_rs2             = issue_grant_s ? dec_rs2 : 5'd0;
    assign ren_rd              = issue_grant_s ? dec_rd  : 5'd0;
    assign ren_retire_phys_reg = retire_grant_s ? fifo_mem_r[rd_ptr_r[AW-1:0]] : 6'd0;
    assign out_valid           = out_valid_r;
    assign out_phys_rd         = out_rd_r;
    assign out_phys_rs1        = out_rs1_r;
    assign out_phys_rs2        = out_rs2_r;
    assign out_old_phys_rd     = out_old_r;
    assign free_count          = free_count_r;
    assign err                 = err_r;

endmodule
